atm_account_core: RTL and testbench



---
 rtl/atm_account_core.sv | 160 ++++++++++++++++
 tb/tb_atm_account_core.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/atm_account_core.sv
// Account core for the ATM: 10-entry PIN/balance store, login check and the
// session FSM that runs balance, withdraw, deposit and PIN-change transactions.
//
// state          | meaning
// ---------------+---------------------------------------------------------
// WAITING        | idle, latch session account when acc_num is valid
// AUTHENTICATION | compare entered PIN against the session account
// MENU           | wait for an operation request (0-2 keep waiting)
// BALANCE        | report balance, flag success
// WITHDRAW       | subtract amount if covered by the balance
// DEPOSIT        | add amount unless the 32-bit balance would overflow
// CHANGE_PIN     | store new_pin for the session account
// EXIT           | never entered; code 7 in MENU returns to WAITING
module atm_account_core (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  operation,
  input  logic [3:0]  acc_num,
  input  logic [15:0] pin,
  input  logic [15:0] new_pin,
  input  logic [31:0] amount,
  output logic [31:0] balance,
  output logic        success,
  output logic [2:0]  state,
  output logic        acc_found,
  output logic        acc_auth
);

  localparam int NUM_ACCOUNTS = 10;

  typedef enum logic [2:0] {
    WAITING        = 3'd0,
    AUTHENTICATION = 3'd1,
    MENU           = 3'd2,
    BALANCE        = 3'd3,
    WITHDRAW       = 3'd4,
    DEPOSIT        = 3'd5,
    CHANGE_PIN     = 3'd6,
    EXIT           = 3'd7
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] pin_db_q [NUM_ACCOUNTS];
  logic [31:0] bal_db_q [NUM_ACCOUNTS];
  logic [3:0]  sess_idx_q, sess_idx_d;
  logic [31:0] balance_q, balance_d;
  logic        success_q, success_d;

  logic [15:0] pin_acc, pin_sess;
  logic [31:0] bal_sess;
  logic [32:0] dep_sum;
  logic        bal_we, pin_we;
  logic [31:0] bal_wdata;

  // Explicit muxes keep out-of-range account numbers from indexing the arrays.
  always_comb begin
    pin_acc  = '0;
    pin_sess = '0;
    bal_sess = '0;
    for (int i = 0; i < NUM_ACCOUNTS; i++) begin
      if (acc_num == 4'(i)) pin_acc = pin_db_q[i];
      if (sess_idx_q == 4'(i)) begin
        pin_sess = pin_db_q[i];
        bal_sess = bal_db_q[i];
      end
    end
  end

  assign acc_found = (acc_num < 4'(NUM_ACCOUNTS));
  assign acc_auth  = acc_found && (pin == pin_acc);
  assign dep_sum   = {1'b0, bal_sess} + {1'b0, amount};

  always_ff @(posedge clk) begin
    if (!rst) state_q <= WAITING;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      WAITING:        if (acc_found) state_d = AUTHENTICATION;
      AUTHENTICATION: state_d = (pin == pin_sess) ? MENU : WAITING;
      MENU: begin
        case (operation)
          BALANCE, WITHDRAW, DEPOSIT, CHANGE_PIN: state_d = state_e'(operation);
          EXIT:                                   state_d = WAITING;
          default:                                state_d = MENU;
        endcase
      end
      default:        state_d = WAITING;
    endcase
  end

  always_comb begin
    sess_idx_d = sess_idx_q;
    success_d  = success_q;
    bal_we     = 1'b0;
    bal_wdata  = bal_sess;
    pin_we     = 1'b0;
    case (state_q)
      WAITING: begin
        if (acc_found) begin
          sess_idx_d = acc_num;
          success_d  = 1'b0;
        end
      end
      BALANCE: success_d = 1'b1;
      WITHDRAW: begin
        if (amount <= bal_sess) begin
          bal_we    = 1'b1;
          bal_wdata = bal_sess - amount;
          success_d = 1'b1;
        end else begin
          success_d = 1'b0;
        end
      end
      DEPOSIT: begin
        if (!dep_sum[32]) begin
          bal_we    = 1'b1;
          bal_wdata = dep_sum[31:0];
          success_d = 1'b1;
        end else begin
          success_d = 1'b0;
        end
      end
      CHANGE_PIN: begin
        pin_we    = 1'b1;
        success_d = 1'b1;
      end
      default: ;
    endcase
    // balance tracks the post-update value, so a write is visible immediately
    balance_d = bal_we ? bal_wdata : bal_sess;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_ACCOUNTS; i++) begin
        pin_db_q[i] <= {4{4'(i)}};
        bal_db_q[i] <= 32'(1000 * (i + 1));
      end
      sess_idx_q <= '0;
      balance_q  <= '0;
      success_q  <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_ACCOUNTS; i++) begin
        if (bal_we && (sess_idx_q == 4'(i))) bal_db_q[i] <= bal_wdata;
        if (pin_we && (sess_idx_q == 4'(i))) pin_db_q[i] <= new_pin;
      end
      sess_idx_q <= sess_idx_d;
      balance_q  <= balance_d;
      success_q  <= success_d;
    end
  end

  assign balance = balance_q;
  assign success = success_q;
  assign state   = state_q;

endmodule

// File: tb/tb_atm_account_core.sv
// Bench for atm_account_core: directed sessions from the test plan followed by
// randomized sessions, all checked against a transaction-level account model.
module tb_atm_account_core;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  operation;
  logic [3:0]  acc_num;
  logic [15:0] pin;
  logic [15:0] new_pin;
  logic [31:0] amount;
  logic [31:0] balance;
  logic        success;
  logic [2:0]  state;
  logic        acc_found;
  logic        acc_auth;

  atm_account_core dut (
    .clk       (clk),
    .rst       (rst),
    .operation (operation),
    .acc_num   (acc_num),
    .pin       (pin),
    .new_pin   (new_pin),
    .amount    (amount),
    .balance   (balance),
    .success   (success),
    .state     (state),
    .acc_found (acc_found),
    .acc_auth  (acc_auth)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errs   = 0;

  // account model
  logic [15:0] mpin [10];
  logic [31:0] mbal [10];
  int          msess;
  logic        msucc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 10; i++) begin
      mpin[i] = {4{i[3:0]}};
      mbal[i] = 32'(1000 * (i + 1));
    end
    msess = 0;
    msucc = 1'b0;
  endtask

  task automatic do_reset();
    rst     = 1'b0;
    acc_num = 4'd15;
    tick();
    model_reset();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_balance", balance, 32'd0);
    chk("rst_success", 32'(success), 32'd0);
    rst = 1'b1;
    tick();
    chk("post_rst_balance", balance, 32'd1000);
    chk("post_rst_state", 32'(state), 32'd0);
  endtask

  // One full session starting in WAITING; expectations come from the model.
  task automatic session(input int acc, input logic [15:0] p, input logic [2:0] op,
                         input logic [31:0] amt, input logic [15:0] np);
    logic [2:0] cur_op;
    logic       exp_auth;
    acc_num   = acc[3:0];
    pin       = p;
    operation = op;
    amount    = amt;
    new_pin   = np;
    #1;
    exp_auth = 1'b0;
    if (acc < 10) exp_auth = (p == mpin[acc]);
    chk("acc_found", 32'(acc_found), (acc < 10) ? 32'd1 : 32'd0);
    chk("acc_auth", 32'(acc_auth), 32'(exp_auth));
    tick();
    if (acc > 9) begin
      chk("idle_state", 32'(state), 32'd0);
      chk("idle_balance", balance, mbal[msess]);
      chk("idle_success", 32'(success), 32'(msucc));
      return;
    end
    chk("login_balance_old", balance, mbal[msess]);
    msess = acc;
    msucc = 1'b0;
    chk("auth_state", 32'(state), 32'd1);
    chk("auth_success", 32'(success), 32'd0);
    acc_num = 4'($urandom);
    tick();
    chk("auth_balance", balance, mbal[msess]);
    if (p != mpin[msess]) begin
      chk("badpin_state", 32'(state), 32'd0);
      return;
    end
    chk("menu_state", 32'(state), 32'd2);
    tick();
    cur_op = op;
    chk("op_balance", balance, mbal[msess]);
    if (cur_op <= 3'd2) begin
      chk("menu_hold", 32'(state), 32'd2);
      cur_op    = 3'(3 + ($urandom % 5));
      operation = cur_op;
      tick();
      chk("op_balance2", balance, mbal[msess]);
    end
    if (cur_op == 3'd7) begin
      chk("exit_state", 32'(state), 32'd0);
      chk("exit_success", 32'(success), 32'd0);
      return;
    end
    chk("op_state", 32'(state), 32'(cur_op));
    operation = 3'($urandom);
    tick();
    case (cur_op)
      3'd3: msucc = 1'b1;
      3'd4: begin
        if (amt <= mbal[msess]) begin
          mbal[msess] = mbal[msess] - amt;
          msucc = 1'b1;
        end else msucc = 1'b0;
      end
      3'd5: begin
        if (longint'(mbal[msess]) + longint'(amt) <= 64'hFFFF_FFFF) begin
          mbal[msess] = mbal[msess] + amt;
          msucc = 1'b1;
        end else msucc = 1'b0;
      end
      default: begin
        mpin[msess] = np;
        msucc = 1'b1;
      end
    endcase
    chk("done_state", 32'(state), 32'd0);
    chk("done_balance", balance, mbal[msess]);
    chk("done_success", 32'(success), 32'(msucc));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    logic [15:0] p;
    logic [31:0] amt;
    rst       = 1'b0;
    operation = '0;
    acc_num   = 4'd15;
    pin       = '0;
    new_pin   = '0;
    amount    = '0;
    model_reset();
    do_reset();

    session(2, 16'h2222, 3'd3, 32'd0, 16'h0);
    chk("plan_bal3000", balance, 32'd3000);
    session(4, 16'h4444, 3'd4, 32'd1500, 16'h0);
    chk("plan_wd_ok", balance, 32'd3500);
    session(4, 16'h4444, 3'd4, 32'd4000, 16'h0);
    chk("plan_wd_fail", 32'(success), 32'd0);
    session(9, 16'h9999, 3'd5, 32'd250, 16'h0);
    chk("plan_dep_ok", balance, 32'd10250);
    session(9, 16'h9999, 3'd5, 32'hFFFF_FFFF, 16'h0);
    chk("plan_dep_ovf", balance, 32'd10250);
    session(1, 16'h0000, 3'd3, 32'd0, 16'h0);
    session(12, 16'h0000, 3'd3, 32'd0, 16'h0);
    session(3, 16'h3333, 3'd4, 32'd0, 16'h0);
    session(3, 16'h3333, 3'd5, 32'd0, 16'h0);
    session(3, 16'h3333, 3'd4, 32'd4000, 16'h0);
    chk("plan_wd_full", balance, 32'd0);
    session(0, 16'h0000, 3'd6, 32'd0, 16'hBEEF);
    chk("plan_pin_chg", 32'(success), 32'd1);
    session(0, 16'h0000, 3'd3, 32'd0, 16'h0);
    session(0, 16'hBEEF, 3'd3, 32'd0, 16'h0);

    // reset while a session sits in MENU
    acc_num   = 4'd0;
    pin       = 16'hBEEF;
    operation = 3'd0;
    tick();
    tick();
    chk("pre_rst_menu", 32'(state), 32'd2);
    do_reset();
    session(0, 16'h0000, 3'd3, 32'd0, 16'h0);
    chk("rst_pin_back", 32'(success), 32'd1);
    session(4, 16'h4444, 3'd3, 32'd0, 16'h0);
    chk("rst_bal_back", balance, 32'd5000);

    for (int n = 0; n < 200; n++) begin
      acc = int'($urandom % 13);
      p   = 16'($urandom);
      amt = $urandom;
      if (acc < 10) begin
        if ($urandom % 4 != 0) p = mpin[acc];
        case ($urandom % 4)
          0: amt = 32'd0;
          1: amt = mbal[acc];
          2: amt = $urandom % 20000;
          default: ;
        endcase
      end
      session(acc, p, 3'($urandom), amt, 16'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
